vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter CLK_DIV, default 4, clk cycles per pixel (legal range 1..16).
REQ-010 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-011 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-012 SHALL have port pos_h, output, 10, current horizontal pixel count.
REQ-013 SHALL have port pos_v, output, 10, current line count.
REQ-014 SHALL have port blank, output, 1, high outside the visible region.
REQ-015 SHALL have port hsync, output, 1, active-low horizontal sync.
REQ-016 SHALL have port vsync, output, 1, active-low vertical sync.
REQ-017 SHALL have port pix_tick, output, 1, one-clk strobe marking the last clk of each pixel period.
REQ-018 SHALL have port frame_start, output, 1, one-clk pulse when the position returns to (0,0).

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-020 SHALL keep a divider counter div_cnt that counts 0..CLK_DIV-1 and wraps to 0.
REQ-021 SHALL assert pix_tick, registered, during exactly the clk cycles where div_cnt == CLK_DIV-1; with CLK_DIV=1, pix_tick SHALL stay high continuously after reset release.
REQ-022 SHALL advance the horizontal counter by 1 only on the clk edge ending a pix_tick cycle, wrapping H_TOTAL-1 -> 0.
REQ-023 SHALL advance the vertical counter by 1 only on the edge where the horizontal counter wraps, wrapping V_TOTAL-1 -> 0.
REQ-024 SHALL drive pos_h and pos_v directly from the counter registers, with zero added latency.
REQ-025 SHALL register blank, hsync and vsync from the next-state counter values, so that they are coherent with pos_h and pos_v in every cycle.
REQ-026 SHALL drive blank = 1 iff pos_h >= H_ACTIVE or pos_v >= V_ACTIVE.
REQ-027 SHALL drive hsync = 0 iff H_ACTIVE+H_FP <= pos_h < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-028 SHALL drive vsync = 0 iff V_ACTIVE+V_FP <= pos_v < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-029 SHALL pulse frame_start for exactly one clk cycle: the first cycle in which pos_h=0 and pos_v=0 after a wrap from (H_TOTAL-1, V_TOTAL-1); it SHALL NOT pulse on reset release.
REQ-030 SHALL hold all outputs except pix_tick and frame_start constant between pixel advances.
REQ-031 SHALL compare all counters at 10-bit width; H_TOTAL and V_TOTAL SHALL each be at most 1024.

Reset
REQ-032 SHALL, while reset is high, force div_cnt=0, pos_h=0, pos_v=0, blank=0, hsync=1, vsync=1, pix_tick=0, frame_start=0.
REQ-033 SHALL, when reset is asserted mid-frame, return all outputs to the REQ-032 values immediately, without waiting for a clock edge.
REQ-034 SHALL, after reset release, assert the first pix_tick in the CLK_DIV-th clk cycle and first advance pos_h to 1 on the following edge.

Verification
REQ-035 Default parameters, run 1 line -> pix_tick period 4 clk; pos_h sequence 0..799 then 0; pos_v increments once; hsync low for exactly 96 pixels starting at pos_h=656.
REQ-036 Run 2 full frames -> frame period 800*525*4 = 1,680,000 clk; vsync low for exactly 2 lines (pos_v 490, 491); frame_start pulses once per frame, 1 clk wide.
REQ-037 Blank check -> blank=0 at (639,479); blank=1 at (640,0), (0,480) and (799,524); blank=0 again at (0,0).
REQ-038 Reset asserted asynchronously at (700,300) between clk edges -> outputs at REQ-032 values before the next edge; after release, pos_h=1 after 4 clk and no frame_start pulse.
REQ-039 CLK_DIV=1 with small timing (H 8/2/2/2, V 4/1/1/1) -> pix_tick constantly high; H_TOTAL=14 and V_TOTAL=7 wrap correctly; frame period is 98 clk.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen.
// master drives position, blanking, syncs and strobes; slave consumes them.
interface vga_sync_gen_if;
    logic [9:0] pos_h;
    logic [9:0] pos_v;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start
    );

    modport slave (
        input pos_h, pos_v, blank, hsync, vsync, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-clock divider, h/v counters, registered
// blank/sync coherent with the position, one-clk frame_start pulse.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        ONE_DIV  = (CLK_DIV == 1);

    logic [3:0] div_cnt;
    logic [3:0] div_nxt;
    logic [9:0] h_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_cnt;
    logic [9:0] v_nxt;
    logic       adv;
    logic       fs_nxt;
    logic       tick_q;
    logic       fs_q;
    logic       blank_q;
    logic       hs_q;
    logic       vs_q;

    // Next-state counters: pixel advance on the last clk of each pixel period.
    always_comb begin
        adv     = (div_cnt == DIV_LAST);
        div_nxt = adv ? 4'd0 : div_cnt + 4'd1;
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        fs_nxt  = 1'b0;
        if (adv) begin
            if (h_cnt == H_LAST) begin
                h_nxt = 10'd0;
                if (v_cnt == V_LAST) begin
                    v_nxt  = 10'd0;
                    fs_nxt = 1'b1;
                end else begin
                    v_nxt = v_cnt + 10'd1;
                end
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    // State and registered outputs, decoded from next-state counters so
    // blank/sync line up with pos_h/pos_v in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 4'd0;
            h_cnt   <= 10'd0;
            v_cnt   <= 10'd0;
            tick_q  <= 1'b0;
            fs_q    <= 1'b0;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            div_cnt <= div_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            tick_q  <= (div_nxt == DIV_LAST);
            fs_q    <= fs_nxt;
            blank_q <= ({1'b0, h_nxt} >= H_VIS) || ({1'b0, v_nxt} >= V_VIS);
            hs_q    <= !(({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
            vs_q    <= !(({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
        end
    end

    // With a divide-by-one clock every cycle is a pixel, so the strobe is
    // simply "not in reset"; otherwise it is the registered divider decode.
    assign vga.pix_tick    = tick_q | (ONE_DIV & ~reset);
    assign vga.pos_h       = h_cnt;
    assign vga.pos_v       = v_cnt;
    assign vga.blank       = blank_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations checked every cycle
// against a time-based arithmetic model, with random async resets.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    longint t = 0;
    bit first_run = 1'b1;
    int hs_low_d = 0;
    int vs_low_m = 0;

    localparam logic [24:0] RST = 25'h000000C;

    always #5 clk = ~clk;

    vga_sync_gen_if d_if ();
    vga_sync_gen_if m_if ();
    vga_sync_gen_if s_if ();

    vga_sync_gen u_d (.clk(clk), .reset(reset), .vga(d_if));

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(4)
    ) u_m (.clk(clk), .reset(reset), .vga(m_if));

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1)
    ) u_s (.clk(clk), .reset(reset), .vga(s_if));

    function automatic logic [24:0] pack(int h, int v, bit b, bit hs,
                                         bit vs, bit tk, bit fs);
        return {10'(h), 10'(v), b, hs, vs, tk, fs};
    endfunction

    // Expected outputs t clks after reset release, straight from the
    // timing definition: pixel index = t / div, raster position from it.
    function automatic logic [24:0] model(int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb,
                                          int d, longint tt);
        longint ht = ha + hf + hs + hb;
        longint vt = va + vf + vs + vb;
        longint p  = tt / d;
        longint ph = tt % d;
        longint h  = p % ht;
        longint v  = (p / ht) % vt;
        bit b  = (h >= ha) || (v >= va);
        bit hy = !((h >= ha + hf) && (h < ha + hf + hs));
        bit vy = !((v >= va + vf) && (v < va + vf + vs));
        bit tk = (ph == d - 1);
        bit fs = (ph == 0) && (p > 0) && (p % (ht * vt) == 0);
        return pack(int'(h), int'(v), b, hy, vy, tk, fs);
    endfunction

    function automatic logic [24:0] md(longint tt);
        return model(640, 16, 96, 48, 480, 10, 2, 33, 4, tt);
    endfunction

    function automatic logic [24:0] mm(longint tt);
        return model(16, 4, 6, 4, 8, 2, 2, 3, 4, tt);
    endfunction

    function automatic logic [24:0] ms(longint tt);
        return model(8, 2, 2, 2, 4, 1, 1, 1, 1, tt);
    endfunction

    task automatic chk(string nm, logic [24:0] act, logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0d actual=%h required=%h",
                         nm, t, act, exp);
        end
    endtask

    // Clks since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    // Per-cycle comparison of all three DUTs against the model.
    always @(negedge clk) begin
        logic [24:0] ad, am, as;
        ad = {d_if.pos_h, d_if.pos_v, d_if.blank, d_if.hsync,
              d_if.vsync, d_if.pix_tick, d_if.frame_start};
        am = {m_if.pos_h, m_if.pos_v, m_if.blank, m_if.hsync,
              m_if.vsync, m_if.pix_tick, m_if.frame_start};
        as = {s_if.pos_h, s_if.pos_v, s_if.blank, s_if.hsync,
              s_if.vsync, s_if.pix_tick, s_if.frame_start};
        if (reset) begin
            chk("rst_def", ad, RST);
            chk("rst_med", am, RST);
            chk("rst_small", as, RST);
        end else begin
            chk("cyc_def", ad, md(t));
            chk("cyc_med", am, mm(t));
            chk("cyc_small", as, ms(t));
            if (first_run && t < 3200 && !d_if.hsync) hs_low_d++;
            if (first_run && t < 1800 && !m_if.vsync) vs_low_m++;
        end
    end

    task automatic async_reset();
        @(posedge clk);
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        chk("async_def", {d_if.pos_h, d_if.pos_v, d_if.blank, d_if.hsync,
            d_if.vsync, d_if.pix_tick, d_if.frame_start}, RST);
        chk("async_med", {m_if.pos_h, m_if.pos_v, m_if.blank, m_if.hsync,
            m_if.vsync, m_if.pix_tick, m_if.frame_start}, RST);
        chk("async_small", {s_if.pos_h, s_if.pos_v, s_if.blank, s_if.hsync,
            s_if.vsync, s_if.pix_tick, s_if.frame_start}, RST);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        chk("pin_tick3", md(3), pack(0, 0, 0, 1, 1, 1, 0));
        chk("pin_adv4", md(4), pack(1, 0, 0, 1, 1, 0, 0));
        chk("pin_hs_on", md(656 * 4), pack(656, 0, 1, 0, 1, 0, 0));
        chk("pin_hs_off", md(752 * 4), pack(752, 0, 1, 1, 1, 0, 0));
        chk("pin_blank640", md(640 * 4 + 3), pack(640, 0, 1, 1, 1, 1, 0));
        chk("pin_line", md(800 * 4), pack(0, 1, 0, 1, 1, 0, 0));
        chk("pin_vis_last", md(479 * 3200 + 639 * 4),
            pack(639, 479, 0, 1, 1, 0, 0));
        chk("pin_vs_on", md(490 * 3200), pack(0, 490, 1, 1, 0, 0, 0));
        chk("pin_last", md(524 * 3200 + 799 * 4),
            pack(799, 524, 1, 1, 1, 0, 0));
        chk("pin_frame", md(1680000), pack(0, 0, 0, 1, 1, 0, 1));
        chk("pin_s97", ms(97), pack(13, 6, 1, 1, 1, 1, 0));
        chk("pin_s98", ms(98), pack(0, 0, 0, 1, 1, 1, 1));
        chk("pin_s80", ms(80), pack(10, 5, 1, 0, 0, 1, 0));

        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rel_tick", 25'(d_if.pix_tick), 25'd1);
        chk("rel_h0", 25'(d_if.pos_h), 25'd0);
        @(posedge clk);
        #1;
        chk("rel_h1", 25'(d_if.pos_h), 25'd1);
        chk("rel_nofs", 25'(d_if.frame_start), 25'd0);

        repeat (12000) @(posedge clk);
        chk("hs_low_clks", 25'(hs_low_d), 25'd384);
        chk("vs_low_clks", 25'(vs_low_m), 25'd240);
        first_run = 1'b0;

        repeat (10) begin
            async_reset();
            repeat ($urandom_range(20, 4000)) @(posedge clk);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
